mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter LED_ADDR, default 9'h100, memory-mapped LED register address.
REQ-002 SHALL have parameter SW_ADDR, default 9'h140, memory-mapped switch input address.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports cpu_cmd  input  2, cpu_addr  input  9, cpu_wdata  input  16: CPU request (cmd 00 none, 01 read, 10 write, 11 illegal).
REQ-006 SHALL have ports cpu_rdata  output  16, cpu_ack  output  1: CPU response.
REQ-007 SHALL have ports ld_cmd  input  2, ld_addr  input  9, ld_wdata  input  16, ld_rdata  output  16, ld_ack  output  1: loader requester, same encoding.
REQ-008 SHALL have ports ram_addr  output  9, ram_write  output  1, ram_din  output  16, ram_dout  input  16: single-port RAM, synchronous read, 1-cycle latency.
REQ-009 SHALL have ports sw  input  8 (switches) and led  output  8 (LED register).
REQ-010 SHALL have port bus_err  output  1: one-cycle pulse on an illegal or unmapped access.

Function
REQ-011 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-012 IDLE: if any cmd != 00, SHALL grant one requester, latch its cmd/addr/wdata, and go to ACCESS; otherwise stay in IDLE.
REQ-013 Arbitration SHALL be 2-way round robin: a lone requester wins; on a tie, the requester not granted last wins.
REQ-014 ACCESS: SHALL drive ram_addr = latched addr and ram_din = latched wdata; ram_write = 1 for exactly this cycle iff the latched cmd is write and addr[8] = 0.
REQ-015 ACCESS, write to LED_ADDR: led SHALL load wdata[7:0] at the end of the cycle.
REQ-016 RESP: SHALL pulse the granted requester's ack for 1 cycle and drive its rdata; the other requester's ack SHALL stay 0.
REQ-017 Read data in RESP SHALL be: ram_dout if addr[8] = 0; {8'h00, led} at LED_ADDR; {8'h00, sw} at SW_ADDR; 16'h0000 otherwise.
REQ-018 Writes to SW_ADDR or unmapped addresses SHALL have no side effect but SHALL still ack.
REQ-019 Unmapped addresses (addr[8] = 1, neither LED_ADDR nor SW_ADDR) or cmd 11 SHALL pulse bus_err in RESP, coincident with ack, with no RAM or LED side effect.
REQ-020 Latency SHALL be fixed: request sampled in IDLE cycle N -> ack in cycle N+2; next grant no earlier than N+3.
REQ-021 Requester input changes after grant SHALL NOT affect the transaction in flight.
REQ-022 rdata SHALL hold its last value between acks; ram_addr SHALL be 0 when not in ACCESS.
REQ-023 A requester holding cmd after its ack SHALL be treated as a new request.

Reset
REQ-024 On reset: state = IDLE; led = 8'h00; cpu_rdata = ld_rdata = 16'h0000; acks, ram_write and bus_err = 0; round-robin pointer set so the CPU wins the first tie.
REQ-025 Reset in ACCESS or RESP SHALL abort the transaction: no ack, no LED update, and ram_write gated low in the reset cycle.

Structure
REQ-026 A shared package SHALL hold the cmd encodings (CMD_NONE/READ/WRITE/ILL), the FSM state enum, and the default LED/SW addresses.
REQ-027 Arbitration SHALL be a sub-module rr_arb2 (req[1:0], advance -> grant one-hot, registered last-grant pointer).

Verification
REQ-028 CPU write 16'h1234 to 9'h010, then read 9'h010 -> ram_write pulses once with addr 9'h010; second ack returns cpu_rdata = 16'h1234, each ack 2 cycles after request.
REQ-029 CPU write 16'hABCD to 9'h100, then read -> led = 8'hCD, ram_write never asserts, read returns 16'h00CD.
REQ-030 sw = 8'h5A, loader reads 9'h140 -> ld_ack with ld_rdata = 16'h005A; cpu_ack stays 0.
REQ-031 Both requesters read continuously from reset -> grants alternate CPU, loader, CPU, ...; each ack spaced 3 cycles apart.
REQ-032 CPU read 9'h1FF, then cmd 11 -> both ack with rdata 16'h0000 and bus_err pulsed; RAM and led unchanged.
REQ-033 Reset asserted during ACCESS of a write to 9'h100 -> no ack, led = 8'h00, FSM in IDLE next cycle.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory bus controller.
// Holds the requester command encodings, the controller FSM state type and
// the default memory-mapped register addresses.
package mem_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_ILL   = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [8:0] LED_ADDR_DEFAULT = 9'h100;
  localparam logic [8:0] SW_ADDR_DEFAULT  = 9'h140;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   req[1:0]   : request vector (bit 0 = CPU, bit 1 = loader)
//   advance    : a grant is being taken this cycle; update the pointer
//   grant[1:0] : one-hot grant (combinational from req and pointer)
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1 when the loader received the most recent grant.
  logic last_ld_q;

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_ld_q ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  // Reset to "loader last" so the CPU takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_ld_q <= 1'b1;
    end else if (advance && (|req)) begin
      last_ld_q <= grant[1];
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: arbitrates a CPU and a loader onto a single-port
// synchronous RAM plus a memory-mapped LED register and switch input.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   cpu_cmd/addr/wdata, cpu_rdata/ack: CPU requester
//   ld_cmd/addr/wdata, ld_rdata/ack  : loader requester
//   ram_addr/write/din, ram_dout     : RAM port (1-cycle read latency)
//   sw, led                          : switch input, LED register output
//   bus_err                          : pulse with ack on illegal/unmapped access
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter logic [8:0] LED_ADDR = LED_ADDR_DEFAULT,
  parameter logic [8:0] SW_ADDR  = SW_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cpu_cmd,
  input  logic [8:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic [1:0]  ld_cmd,
  input  logic [8:0]  ld_addr,
  input  logic [15:0] ld_wdata,
  output logic [15:0] ld_rdata,
  output logic        ld_ack,
  output logic [8:0]  ram_addr,
  output logic        ram_write,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout,
  input  logic [7:0]  sw,
  output logic [7:0]  led,
  output logic        bus_err
);

  state_e      state_q, state_d;
  cmd_e        cmd_q;
  logic [8:0]  addr_q;
  logic [15:0] wdata_q;
  logic        sel_ld_q;
  logic [7:0]  led_q;
  logic [15:0] cpu_rdata_q, ld_rdata_q;

  logic [1:0]  req_vec;
  logic [1:0]  grant;
  logic        advance;

  assign req_vec = {ld_cmd != CMD_NONE, cpu_cmd != CMD_NONE};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_vec),
    .advance (advance),
    .grant   (grant)
  );

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_vec) begin
          advance = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address decode of the latched request.
  logic        is_ram, is_led, is_sw, is_ill, unmapped;
  logic        in_access, resp_live;
  logic        led_we;
  logic [15:0] rd_val;

  assign is_ram   = ~addr_q[8];
  assign is_led   = (addr_q == LED_ADDR);
  assign is_sw    = (addr_q == SW_ADDR);
  assign is_ill   = (cmd_q == CMD_ILL);
  assign unmapped = addr_q[8] && !is_led && !is_sw;

  // Reset gates the in-flight cycle so an aborted transaction has no effect.
  assign in_access = (state_q == ACCESS) && !reset;
  assign resp_live = (state_q == RESP) && !reset;

  always_comb begin
    rd_val = '0;
    if (!is_ill) begin
      if (is_ram)      rd_val = ram_dout;
      else if (is_led) rd_val = {8'h00, led_q};
      else if (is_sw)  rd_val = {8'h00, sw};
    end
  end

  assign ram_addr  = in_access ? addr_q : '0;
  assign ram_din   = in_access ? wdata_q : '0;
  assign ram_write = in_access && (cmd_q == CMD_WRITE) && is_ram;
  assign led_we    = in_access && (cmd_q == CMD_WRITE) && is_led;

  assign cpu_ack = resp_live && !sel_ld_q;
  assign ld_ack  = resp_live && sel_ld_q;
  assign bus_err = resp_live && (is_ill || unmapped);
  assign led     = led_q;

  // RAM data only exists during RESP, so rdata bypasses the holding register
  // in the ack cycle and the register keeps it afterwards.
  assign cpu_rdata = cpu_ack ? rd_val : cpu_rdata_q;
  assign ld_rdata  = ld_ack  ? rd_val : ld_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= CMD_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_ld_q    <= 1'b0;
      led_q       <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (advance) begin
        sel_ld_q <= grant[1];
        cmd_q    <= cmd_e'(grant[1] ? ld_cmd : cpu_cmd);
        addr_q   <= grant[1] ? ld_addr : cpu_addr;
        wdata_q  <= grant[1] ? ld_wdata : cpu_wdata;
      end
      if (led_we)  led_q       <= wdata_q[7:0];
      if (cpu_ack) cpu_rdata_q <= rd_val;
      if (ld_ack)  ld_rdata_q  <= rd_val;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cpu_cmd, ld_cmd;
  logic [8:0]  cpu_addr, ld_addr;
  logic [15:0] cpu_wdata, ld_wdata;
  logic [15:0] cpu_rdata, ld_rdata;
  logic        cpu_ack, ld_ack;
  logic [8:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [7:0]  sw, led;
  logic        bus_err;

  mem_bus_ctrl #(.LED_ADDR(9'h100), .SW_ADDR(9'h140)) dut (
    .clk(clk), .reset(reset),
    .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ld_cmd(ld_cmd), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din),
    .ram_dout(ram_dout), .sw(sw), .led(led), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Behavioural read-first synchronous RAM.
  logic [15:0] mem [512];
  initial for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int ramw_count = 0;
  int ack_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        who;      // 0 CPU, 1 loader
    logic [15:0] rdata;
    logic        chk;
    logic        err;
    int unsigned cyc;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  // Scoreboard consumer: every ack must match the oldest expectation.
  always @(negedge clk) begin
    if (ram_write) ramw_count++;
    if (cpu_ack || ld_ack) begin
      ack_count++;
      if (sbq.size() == 0) begin
        check("unexpected_ack", {30'b0, cpu_ack, ld_ack}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("ack_who", {30'b0, cpu_ack, ld_ack}, mon_e.who ? 32'd1 : 32'd2);
        if (mon_e.chk) check("ack_rdata", {16'b0, mon_e.who ? ld_rdata : cpu_rdata}, {16'b0, mon_e.rdata});
        check("ack_bus_err", {31'b0, bus_err}, {31'b0, mon_e.err});
        check("ack_cycle", cyc, mon_e.cyc);
        check("ram_addr_resp", {23'b0, ram_addr}, 32'd0);
      end
    end else if (bus_err) begin
      check("bus_err_without_ack", {31'b0, bus_err}, 32'd0);
    end
  end

  typedef struct {
    logic        who;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        chk;
    logic        exp_err;
    logic        exp_ramw;
    logic [7:0]  exp_led;
  } vec_t;

  function automatic vec_t mk(logic who, logic [1:0] cmd, logic [8:0] addr, logic [15:0] wdata,
                              logic [15:0] r, logic chk, logic err, logic ramw, logic [7:0] l);
    vec_t v;
    v.who = who; v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.exp_rdata = r;
    v.chk = chk; v.exp_err = err; v.exp_ramw = ramw; v.exp_led = l;
    return v;
  endfunction

  task automatic drive(input logic who, input logic [1:0] cmd, input logic [8:0] a, input logic [15:0] d);
    if (!who) begin cpu_cmd = cmd; cpu_addr = a; cpu_wdata = d; end
    else      begin ld_cmd  = cmd; ld_addr  = a; ld_wdata  = d; end
  endtask

  task automatic do_txn(input vec_t v);
    @(posedge clk); #1;
    drive(v.who, v.cmd, v.addr, v.wdata);
    sbq.push_back('{v.who, v.exp_rdata, v.chk, v.exp_err, cyc + 2});
    @(posedge clk); #1;
    // Drop the request and scramble the bus while the access is in flight.
    cpu_cmd = CMD_NONE; ld_cmd = CMD_NONE;
    cpu_addr = 9'($urandom); ld_addr = 9'($urandom);
    cpu_wdata = 16'($urandom); ld_wdata = 16'($urandom);
    @(negedge clk);
    check("access_ram_write", {31'b0, ram_write}, {31'b0, v.exp_ramw});
    check("access_ram_addr", {23'b0, ram_addr}, {23'b0, v.addr});
    if (v.exp_ramw) check("access_ram_din", {16'b0, ram_din}, {16'b0, v.wdata});
    @(posedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("led_after_txn", {24'b0, led}, {24'b0, v.exp_led});
  endtask

  vec_t tbl[14];
  int   exp_ramw;
  int   ramw_base;
  int   ack_base;
  int unsigned k0;

  initial begin
    tbl[0]  = mk(0, CMD_WRITE, 9'h010, 16'h1234, 16'h0000, 0, 0, 1, 8'h00);
    tbl[1]  = mk(0, CMD_READ,  9'h010, 16'h0000, 16'h1234, 1, 0, 0, 8'h00);
    tbl[2]  = mk(0, CMD_WRITE, 9'h100, 16'hABCD, 16'h0000, 0, 0, 0, 8'hCD);
    tbl[3]  = mk(0, CMD_READ,  9'h100, 16'h0000, 16'h00CD, 1, 0, 0, 8'hCD);
    tbl[4]  = mk(1, CMD_READ,  9'h140, 16'h0000, 16'h005A, 1, 0, 0, 8'hCD);
    tbl[5]  = mk(0, CMD_READ,  9'h1FF, 16'h0000, 16'h0000, 1, 1, 0, 8'hCD);
    tbl[6]  = mk(0, CMD_ILL,   9'h010, 16'h9999, 16'h0000, 1, 1, 0, 8'hCD);
    tbl[7]  = mk(1, CMD_WRITE, 9'h140, 16'h00FF, 16'h0000, 0, 0, 0, 8'hCD);
    tbl[8]  = mk(1, CMD_WRITE, 9'h1C0, 16'h00EE, 16'h0000, 0, 1, 0, 8'hCD);
    tbl[9]  = mk(1, CMD_READ,  9'h010, 16'h0000, 16'h1234, 1, 0, 0, 8'hCD);
    tbl[10] = mk(1, CMD_WRITE, 9'h020, 16'h5555, 16'h0000, 0, 0, 1, 8'hCD);
    tbl[11] = mk(0, CMD_READ,  9'h020, 16'h0000, 16'h5555, 1, 0, 0, 8'hCD);
    tbl[12] = mk(1, CMD_WRITE, 9'h100, 16'h0042, 16'h0000, 0, 0, 0, 8'h42);
    tbl[13] = mk(1, CMD_READ,  9'h100, 16'h0000, 16'h0042, 1, 0, 0, 8'h42);

    reset = 1'b1; sw = 8'h5A;
    cpu_cmd = CMD_NONE; cpu_addr = '0; cpu_wdata = '0;
    ld_cmd  = CMD_NONE; ld_addr  = '0; ld_wdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {28'b0, cpu_ack, ld_ack, bus_err, ram_write}, 32'd0);
    check("reset_cpu_rdata", {16'b0, cpu_rdata}, 32'd0);
    check("reset_ld_rdata", {16'b0, ld_rdata}, 32'd0);
    check("reset_led", {24'b0, led}, 32'd0);
    check("reset_ram_addr", {23'b0, ram_addr}, 32'd0);

    // Both requesters hold a read from reset: CPU first, then alternate.
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, CMD_READ, 9'h140, 16'h0000);
    drive(1, CMD_READ, 9'h100, 16'h0000);
    k0 = cyc;
    sbq.push_back('{1'b0, 16'h005A, 1'b1, 1'b0, k0 + 2});
    sbq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, k0 + 5});
    sbq.push_back('{1'b0, 16'h005A, 1'b1, 1'b0, k0 + 8});
    sbq.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, k0 + 11});
    repeat (12) @(posedge clk); #1;
    cpu_cmd = CMD_NONE; ld_cmd = CMD_NONE;
    repeat (3) @(posedge clk); #1;
    check("alternate_drained", sbq.size(), 32'd0);

    ramw_base = ramw_count;
    exp_ramw = 0;
    for (int i = 0; i < 14; i++) begin
      do_txn(tbl[i]);
      exp_ramw += int'(tbl[i].exp_ramw);
    end
    check("ram_write_pulses", ramw_count - ramw_base, exp_ramw);
    check("cpu_rdata_hold", {16'b0, cpu_rdata}, 32'h5555);
    check("ld_rdata_hold", {16'b0, ld_rdata}, 32'h0042);

    // Reset during ACCESS of an LED write: aborted, LED cleared, no ack.
    ack_base = ack_count;
    @(posedge clk); #1;
    drive(1, CMD_WRITE, 9'h100, 16'h0077);
    @(posedge clk); #1;
    reset = 1'b1; ld_cmd = CMD_NONE;
    @(negedge clk);
    check("rst_access_ram_write", {31'b0, ram_write}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_no_ack", ack_count - ack_base, 32'd0);
    check("rst_led_cleared", {24'b0, led}, 32'd0);

    // Reset during ACCESS of a RAM write: write gated, then IDLE immediately.
    ramw_base = ramw_count;
    @(posedge clk); #1;
    drive(0, CMD_WRITE, 9'h010, 16'hBEEF);
    @(posedge clk); #1;
    reset = 1'b1; cpu_cmd = CMD_NONE;
    @(negedge clk);
    check("rst_gate_ram_write", {31'b0, ram_write}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, CMD_READ, 9'h010, 16'h0000);
    sbq.push_back('{1'b0, 16'h1234, 1'b1, 1'b0, cyc + 2});
    @(posedge clk); #1;
    cpu_cmd = CMD_NONE;
    repeat (4) @(posedge clk); #1;
    check("rst_no_ram_write", ramw_count - ramw_base, 32'd0);
    check("final_sb_empty", sbq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout cycle=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
